// File: rtl/ecap5_dproc_pkg.sv
// Shared ECAP5-DPROC definitions: opcodes, ALU operation codes, branch kinds
// and load/store byte-select constants used by the decode stage.
package ecap5_dproc_pkg;

    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [3:0] LS_SEL_BYTE = 4'b0001;
    localparam logic [3:0] LS_SEL_HALF = 4'b0011;
    localparam logic [3:0] LS_SEL_WORD = 4'b1111;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        BEQ    = 3'd1,
        BNE    = 3'd2,
        BLT    = 3'd3,
        BGE    = 3'd4,
        BLTU   = 3'd5,
        BGEU   = 3'd6,
        UNCOND = 3'd7
    } branch_cond_t;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  alu_operand1;
        logic [31:0]  alu_operand2;
        logic [2:0]   alu_op;
        logic         alu_sub;
        logic         alu_shift_left;
        logic         alu_signed_shift;
        logic         reg_write;
        logic [4:0]   reg_addr;
        branch_cond_t branch_cond;
        logic         branch_jalr;
        logic [19:0]  branch_offset;
        logic         ls_enable;
        logic         ls_write;
        logic         ls_unsigned;
        logic [3:0]   ls_sel;
        logic [31:0]  ls_wdata;
    } dm_bundle_t;

    // Undefined encodings (funct3 = 010/011) return NONE.
    function automatic branch_cond_t branch_cond_from_funct3(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return BEQ;
            3'b001:  return BNE;
            3'b100:  return BLT;
            3'b101:  return BGE;
            3'b110:  return BLTU;
            3'b111:  return BGEU;
            default: return NONE;
        endcase
    endfunction

    function automatic logic [3:0] ls_sel_from_width(input logic [1:0] width);
        case (width)
            2'b00:   return LS_SEL_BYTE;
            2'b01:   return LS_SEL_HALF;
            default: return LS_SEL_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dm_imm.sv
// Combinational RV32I immediate extraction (I/S/B/U/J), all sign-extended to
// 32 bits. Only instruction bits [31:7] carry immediate information.
module dm_imm
    import ecap5_dproc_pkg::*;
(
    input  logic [31:7] instr_i,
    output logic [31:0] imm_i_o,
    output logic [31:0] imm_s_o,
    output logic [31:0] imm_b_o,
    output logic [31:0] imm_u_o,
    output logic [31:0] imm_j_o
);

    assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
    assign imm_u_o = {instr_i[31:12], 12'b0};
    assign imm_j_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};

endmodule

// File: rtl/dm.sv
// ECAP5-DPROC decode stage: one-entry registered execute bundle behind ready/valid.
// Optional DM_ILLEGAL_EN adds a registered illegal-instruction flag.
module dm
    import ecap5_dproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,

    output logic [4:0]  rdt_addr1_o,
    output logic [4:0]  rdt_addr2_o,
    input  logic [31:0] rdt_data1_i,
    input  logic [31:0] rdt_data2_i,

    output logic        output_valid_o,
    input  logic        output_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] alu_operand1_o,
    output logic [31:0] alu_operand2_o,
    output logic [2:0]  alu_op_o,
    output logic        alu_sub_o,
    output logic        alu_shift_left_o,
    output logic        alu_signed_shift_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [2:0]  branch_cond_o,
    output logic        branch_jalr_o,
    output logic [19:0] branch_offset_o,
    output logic        ls_enable_o,
    output logic        ls_write_o,
    output logic        ls_unsigned_o,
    output logic [3:0]  ls_sel_o,
    output logic [31:0] ls_wdata_o,
    output logic        illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        accept;
    logic        illegal_d;
    logic        valid_d, valid_q;
    dm_bundle_t  dec;
    dm_bundle_t  bundle_d, bundle_q;
    logic        unused_imm_bits;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd     = instr_i[11:7];

    assign rdt_addr1_o = instr_i[19:15];
    assign rdt_addr2_o = instr_i[24:20];

    dm_imm u_imm (
        .instr_i (instr_i[31:7]),
        .imm_i_o (imm_i),
        .imm_s_o (imm_s),
        .imm_b_o (imm_b),
        .imm_u_o (imm_u),
        .imm_j_o (imm_j)
    );

    // Branch/jump immediates only contribute bits [20:1] to the offset.
    assign unused_imm_bits = ^{imm_b[31:21], imm_b[0], imm_j[31:21], imm_j[0]};

    assign input_ready_o = !valid_q || output_ready_i;
    assign accept        = input_valid_i && input_ready_o;

    always_comb begin
        dec             = '0;
        dec.pc          = pc_i;
        dec.branch_cond = NONE;
        illegal_d       = 1'b0;
        case (opcode)
            OPCODE_LUI: begin
                dec.alu_operand2 = imm_u;
                dec.reg_write    = 1'b1;
            end
            OPCODE_AUIPC: begin
                dec.alu_operand1 = pc_i;
                dec.alu_operand2 = imm_u;
                dec.reg_write    = 1'b1;
            end
            OPCODE_JAL: begin
                dec.alu_operand1  = pc_i;
                dec.alu_operand2  = 32'd4;
                dec.reg_write     = 1'b1;
                dec.branch_cond   = UNCOND;
                dec.branch_offset = imm_j[20:1];
            end
            OPCODE_JALR: begin
                dec.alu_operand1  = pc_i;
                dec.alu_operand2  = 32'd4;
                dec.reg_write     = 1'b1;
                dec.branch_cond   = UNCOND;
                dec.branch_jalr   = 1'b1;
                dec.branch_offset = imm_i[20:1];
            end
            OPCODE_BRANCH: begin
                dec.alu_operand1  = rdt_data1_i;
                dec.alu_operand2  = rdt_data2_i;
                dec.alu_sub       = 1'b1;
                dec.branch_cond   = branch_cond_from_funct3(funct3);
                dec.branch_offset = imm_b[20:1];
                illegal_d         = (dec.branch_cond == NONE);
            end
            OPCODE_LOAD: begin
                dec.alu_operand1 = rdt_data1_i;
                dec.alu_operand2 = imm_i;
                dec.reg_write    = 1'b1;
                dec.ls_enable    = 1'b1;
                dec.ls_unsigned  = funct3[2];
                dec.ls_sel       = ls_sel_from_width(funct3[1:0]);
                // Legal widths: LB, LH, LW, LBU, LHU.
                illegal_d        = (funct3[1:0] == 2'b11) || (funct3[2] && funct3[1]);
            end
            OPCODE_STORE: begin
                dec.alu_operand1 = rdt_data1_i;
                dec.alu_operand2 = imm_s;
                dec.ls_enable    = 1'b1;
                dec.ls_write     = 1'b1;
                dec.ls_sel       = ls_sel_from_width(funct3[1:0]);
                dec.ls_wdata     = rdt_data2_i;
                illegal_d        = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPCODE_OP_IMM: begin
                dec.alu_operand1     = rdt_data1_i;
                dec.alu_operand2     = imm_i;
                dec.alu_op           = funct3;
                dec.reg_write        = 1'b1;
                dec.alu_shift_left   = (funct3 == ALU_SLL);
                dec.alu_signed_shift = (funct3 == ALU_SR) && funct7[5];
                illegal_d = ((funct3 == ALU_SLL) && (funct7 != FUNCT7_BASE)) ||
                            ((funct3 == ALU_SR) && (funct7 != FUNCT7_BASE) &&
                             (funct7 != FUNCT7_ALT));
            end
            OPCODE_OP: begin
                dec.alu_operand1     = rdt_data1_i;
                dec.alu_operand2     = rdt_data2_i;
                dec.alu_op           = funct3;
                dec.reg_write        = 1'b1;
                dec.alu_sub          = (funct3 == ALU_ADD) && funct7[5];
                dec.alu_shift_left   = (funct3 == ALU_SLL);
                dec.alu_signed_shift = (funct3 == ALU_SR) && funct7[5];
                illegal_d = !((funct7 == FUNCT7_BASE) ||
                              ((funct7 == FUNCT7_ALT) &&
                               ((funct3 == ALU_ADD) || (funct3 == ALU_SR))));
            end
            OPCODE_MISC_MEM, OPCODE_SYSTEM: begin
                illegal_d = 1'b0;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase

        // Writes to x0 are dropped here so execute never sees them.
        if (rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
        dec.reg_addr = dec.reg_write ? rd : 5'd0;

        bundle_d = dec;
        if (illegal_d) begin
            bundle_d             = '0;
            bundle_d.pc          = pc_i;
            bundle_d.branch_cond = NONE;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
        end else if (output_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                bundle_q <= bundle_d;
            end
        end
    end

`ifdef DM_ILLEGAL_EN
    logic illegal_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            illegal_q <= 1'b0;
        end else if (accept) begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

    assign output_valid_o     = valid_q;
    assign pc_o               = bundle_q.pc;
    assign alu_operand1_o     = bundle_q.alu_operand1;
    assign alu_operand2_o     = bundle_q.alu_operand2;
    assign alu_op_o           = bundle_q.alu_op;
    assign alu_sub_o          = bundle_q.alu_sub;
    assign alu_shift_left_o   = bundle_q.alu_shift_left;
    assign alu_signed_shift_o = bundle_q.alu_signed_shift;
    assign reg_write_o        = bundle_q.reg_write;
    assign reg_addr_o         = bundle_q.reg_addr;
    assign branch_cond_o      = bundle_q.branch_cond;
    assign branch_jalr_o      = bundle_q.branch_jalr;
    assign branch_offset_o    = bundle_q.branch_offset;
    assign ls_enable_o        = bundle_q.ls_enable;
    assign ls_write_o         = bundle_q.ls_write;
    assign ls_unsigned_o      = bundle_q.ls_unsigned;
    assign ls_sel_o           = bundle_q.ls_sel;
    assign ls_wdata_o         = bundle_q.ls_wdata;

endmodule

// File: tb/tb_dm.sv
// Testbench for dm: directed RV32I decode cases, stall/reset sequences and
// randomized traffic checked against an instruction-level reference model.
module tb_dm;

    logic        clk;
    logic        rst;
    logic        input_valid;
    logic        input_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rdt_addr1, rdt_addr2;
    logic [31:0] rdt_data1, rdt_data2;
    logic        output_valid;
    logic        output_ready;
    logic [31:0] pc_o, op1_o, op2_o, ls_wdata_o;
    logic [2:0]  alu_op_o, branch_cond_o;
    logic        alu_sub_o, alu_sl_o, alu_ss_o, reg_write_o, jalr_o;
    logic [4:0]  reg_addr_o;
    logic [19:0] offset_o;
    logic        ls_en_o, ls_wr_o, ls_uns_o, illegal_o;
    logic [3:0]  ls_sel_o;

    logic [31:0] rf [32];
    assign rdt_data1 = rf[rdt_addr1];
    assign rdt_data2 = rf[rdt_addr2];

    dm dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .input_valid_i      (input_valid),
        .input_ready_o      (input_ready),
        .instr_i            (instr),
        .pc_i               (pc),
        .rdt_addr1_o        (rdt_addr1),
        .rdt_addr2_o        (rdt_addr2),
        .rdt_data1_i        (rdt_data1),
        .rdt_data2_i        (rdt_data2),
        .output_valid_o     (output_valid),
        .output_ready_i     (output_ready),
        .pc_o               (pc_o),
        .alu_operand1_o     (op1_o),
        .alu_operand2_o     (op2_o),
        .alu_op_o           (alu_op_o),
        .alu_sub_o          (alu_sub_o),
        .alu_shift_left_o   (alu_sl_o),
        .alu_signed_shift_o (alu_ss_o),
        .reg_write_o        (reg_write_o),
        .reg_addr_o         (reg_addr_o),
        .branch_cond_o      (branch_cond_o),
        .branch_jalr_o      (jalr_o),
        .branch_offset_o    (offset_o),
        .ls_enable_o        (ls_en_o),
        .ls_write_o         (ls_wr_o),
        .ls_unsigned_o      (ls_uns_o),
        .ls_sel_o           (ls_sel_o),
        .ls_wdata_o         (ls_wdata_o),
        .illegal_o          (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, op1, op2;
        logic [2:0]  alu_op;
        logic        sub, sl, ss, rw;
        logic [4:0]  rd;
        logic [2:0]  bc;
        logic        jalr;
        logic [19:0] off;
        logic        ls_en, ls_wr, ls_uns;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        ill;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_b;
    logic exp_valid;
    logic [6:0] opc_tab [12];

    `ifdef DM_ILLEGAL_EN
    localparam logic ILL_FLAG = 1'b1;
    `else
    localparam logic ILL_FLAG = 1'b0;
    `endif

    // Legality per the RV32I base encoding table.
    function automatic logic is_legal(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73: return 1'b1;
            7'h63: return !(f3 == 3'd2 || f3 == 3'd3);
            7'h03: return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            7'h23: return (f3 < 3);
            7'h13: return !((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20));
            7'h33: return (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic [2:0] f3;
        logic [1:0] w;
        f3    = ins[14:12];
        w     = ins[13:12];
        imm_i = $signed(ins) >>> 20;
        imm_s = (imm_i & 32'hFFFF_FFE0) | {27'b0, ins[11:7]};
        b13   = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_b = 32'(b13);
        j21   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm_j = 32'(j21);
        imm_u = ins & 32'hFFFF_F000;
        e = '0;
        e.pc = p;
        case (ins[6:0])
            7'h37: begin e.op2 = imm_u; e.rw = 1; end
            7'h17: begin e.op1 = p; e.op2 = imm_u; e.rw = 1; end
            7'h6F: begin e.op1 = p; e.op2 = 4; e.rw = 1; e.bc = 7; e.off = imm_j[20:1]; end
            7'h67: begin e.op1 = p; e.op2 = 4; e.rw = 1; e.bc = 7; e.jalr = 1; e.off = imm_i[20:1]; end
            7'h63: begin
                e.op1 = r1; e.op2 = r2; e.sub = 1; e.off = imm_b[20:1];
                case (f3)
                    3'd0: e.bc = 1;
                    3'd1: e.bc = 2;
                    3'd4: e.bc = 3;
                    3'd5: e.bc = 4;
                    3'd6: e.bc = 5;
                    3'd7: e.bc = 6;
                    default: e.bc = 0;
                endcase
            end
            7'h03: begin
                e.op1 = r1; e.op2 = imm_i; e.rw = 1; e.ls_en = 1; e.ls_uns = f3[2];
                e.sel = (w == 0) ? 4'h1 : (w == 1) ? 4'h3 : 4'hF;
            end
            7'h23: begin
                e.op1 = r1; e.op2 = imm_s; e.ls_en = 1; e.ls_wr = 1; e.wdata = r2;
                e.sel = (w == 0) ? 4'h1 : (w == 1) ? 4'h3 : 4'hF;
            end
            7'h13, 7'h33: begin
                e.op1 = r1; e.op2 = (ins[6:0] == 7'h13) ? imm_i : r2;
                e.alu_op = f3; e.rw = 1;
                e.sl = (f3 == 1);
                e.ss = (f3 == 5) && ins[30];
                e.sub = (ins[6:0] == 7'h33) && (f3 == 0) && ins[30];
            end
            default: ;
        endcase
        if (!is_legal(ins)) begin
            e = '0;
            e.pc = p;
            e.ill = ILL_FLAG;
        end
        if (ins[11:7] == 5'd0) e.rw = 0;
        e.rd = e.rw ? ins[11:7] : 5'd0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {63'b0, output_valid}, {63'b0, exp_valid});
        chk("pc", {32'b0, pc_o}, {32'b0, exp_b.pc});
        chk("op1", {32'b0, op1_o}, {32'b0, exp_b.op1});
        chk("op2", {32'b0, op2_o}, {32'b0, exp_b.op2});
        chk("wdata", {32'b0, ls_wdata_o}, {32'b0, exp_b.wdata});
        chk("ctl",
            {20'b0, alu_op_o, alu_sub_o, alu_sl_o, alu_ss_o, reg_write_o, reg_addr_o,
             branch_cond_o, jalr_o, offset_o, ls_en_o, ls_wr_o, ls_uns_o, ls_sel_o, illegal_o},
            {20'b0, exp_b.alu_op, exp_b.sub, exp_b.sl, exp_b.ss, exp_b.rw, exp_b.rd,
             exp_b.bc, exp_b.jalr, exp_b.off, exp_b.ls_en, exp_b.ls_wr, exp_b.ls_uns,
             exp_b.sel, exp_b.ill});
    endtask

    // Called 1 time unit after a rising edge; drives one cycle and checks both sides.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic ordy);
        logic acc;
        input_valid  = v;
        instr        = ins;
        pc           = p;
        output_ready = ordy;
        #1;
        chk("in_ready", {63'b0, input_ready}, {63'b0, (!exp_valid || ordy)});
        chk("rs_addr", {54'b0, rdt_addr1, rdt_addr2}, {54'b0, ins[19:15], ins[24:20]});
        acc = v && (!exp_valid || ordy);
        if (acc) begin
            exp_b     = model(ins, p, rf[ins[19:15]], rf[ins[24:20]]);
            exp_valid = 1'b1;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int idx;
        ins = $urandom;
        idx = $urandom_range(0, 11);
        if (idx < 11) ins[6:0] = opc_tab[idx];
        if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return ins;
    endfunction

    initial begin
        opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                    7'h0F, 7'h73, 7'h7F};
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst          = 1'b1;
        input_valid  = 1'b0;
        instr        = 32'd0;
        pc           = 32'd0;
        output_ready = 1'b0;
        exp_valid    = 1'b0;
        exp_b        = '0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready", {63'b0, input_ready}, 64'd1);
        check_outputs();
        rst = 1'b0;

        // Directed decode cases, back to back
        cycle(1'b1, 32'h0050_0093, 32'h0000_0040, 1'b1);
        chk("addi_op2", {32'b0, op2_o}, 64'd5);
        chk("addi_rd", {59'b0, reg_addr_o}, 64'd1);

        rf[1] = 32'd10;
        rf[2] = 32'd3;
        cycle(1'b1, 32'h4020_81B3, 32'h0000_0044, 1'b1);
        chk("sub_ops", {op1_o, op2_o}, {32'd10, 32'd3});
        chk("sub_flag", {63'b0, alu_sub_o}, 64'd1);

        cycle(1'b1, 32'h0020_8463, 32'h0000_0100, 1'b1);
        chk("beq_cond", {61'b0, branch_cond_o}, 64'd1);
        chk("beq_off", {44'b0, offset_o}, 64'd4);

        cycle(1'b1, 32'h0100_00EF, 32'h0000_0200, 1'b1);
        chk("jal_op1", {32'b0, op1_o}, 64'h200);
        chk("jal_off", {44'b0, offset_o, 3'b0, branch_cond_o}, {44'b0, 20'd8, 3'b0, 3'd7});

        // Stall: downstream busy for three cycles, then release
        cycle(1'b1, 32'h0010_0113, 32'h0000_0300, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h0020_0193, 32'h0000_0304, 1'b0);
            chk("stall_ready", {63'b0, input_ready}, 64'd0);
        end
        cycle(1'b1, 32'h0020_0193, 32'h0000_0304, 1'b1);
        cycle(1'b1, 32'h0030_0213, 32'h0000_0308, 1'b1);
        chk("no_bubble", {32'b0, pc_o}, 64'h308);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Illegal opcode with rd=x1
        cycle(1'b1, 32'h0000_00FF, 32'h0000_0400, 1'b0);
        chk("ill_rw", {63'b0, reg_write_o}, 64'd0);
        chk("ill_flag", {63'b0, illegal_o}, {63'b0, ILL_FLAG});

        // Asynchronous reset with a valid bundle held
        input_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_valid = 1'b0;
        exp_b     = '0;
        chk("rst_async_valid", {63'b0, output_valid}, 64'd0);
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 1; i < 32; i++) rf[i] = $urandom;
            cycle(($urandom_range(0, 3) != 0), rand_instr(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm.md
# dm

Decode module of the ECAP5-DPROC pipeline, directly downstream of the instruction fetch module (ifm). It accepts one 32-bit RV32I instruction and its PC per ready/valid handshake and reads rs1/rs2 from the register file. It registers a fully decoded execute-stage bundle (ALU operands and controls, writeback target, branch and load/store controls) behind an output ready/valid handshake.

## Interface
- No parameters.
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- input_valid_i  in  1  ifm has an instruction
- input_ready_o  out  1  dm accepts this cycle
- instr_i  in  32  instruction word
- pc_i  in  32  instruction address
- rdt_addr1_o / rdt_addr2_o  out  5  combinational rs1/rs2 index, instr_i[19:15] / instr_i[24:20]
- rdt_data1_i / rdt_data2_i  in  32  register file data, same-cycle (combinational read)
- output_valid_o  out  1  bundle valid
- output_ready_i  in  1  execute accepts bundle
- pc_o  out  32  registered PC
- alu_operand1_o / alu_operand2_o  out  32  ALU inputs
- alu_op_o  out  3  funct3-style ALU operation
- alu_sub_o, alu_shift_left_o, alu_signed_shift_o  out  1 each  ALU modifiers
- reg_write_o  out  1  writeback enable; reg_addr_o  out  5  rd
- branch_cond_o  out  3  branch kind (package enum); branch_jalr_o  out  1  target is rs1-relative
- branch_offset_o  out  20  immediate >> 1, truncated to 20 bits (matches ifm boffset_i)
- ls_enable_o, ls_write_o, ls_unsigned_o  out  1 each; ls_sel_o  out  4; ls_wdata_o  out  32  (rs2)
- illegal_o  out  1  only with DM_ILLEGAL_EN; otherwise tied 0

## Operation
- input_ready_o = !output_valid_o || output_ready_i (single-entry pipeline register, full throughput).
- Accept (input_valid_i && input_ready_o): decode, register all outputs, set output_valid_o.
- Output handshake without accept: output_valid_o clears; registered fields hold.
- Neither handshake: all outputs hold stable while output_valid_o=1.
- Decode per opcode:
  - LUI: op1=0, op2=U-imm, ADD, reg_write.
  - AUIPC: op1=pc, op2=U-imm, ADD.
  - JAL: op1=pc, op2=4, ADD, reg_write, branch_cond=UNCOND, offset=J-imm>>1.
  - JALR: as JAL plus branch_jalr_o=1, offset=I-imm>>1.
  - BRANCH: op1=rs1, op2=rs2, alu_sub=1, reg_write=0, cond from funct3, offset=B-imm>>1.
  - LOAD/STORE: op1=rs1, op2=I/S-imm, ADD, ls_enable; store sets ls_write, reg_write=0; ls_sel from funct3 width (byte 0001, half 0011, word 1111); ls_unsigned for LBU/LHU.
  - OP-IMM/OP: op1=rs1, op2=I-imm/rs2, alu_op=funct3; alu_sub for OP funct7[5] with ADD; shifts set shift_left (SLL) or signed_shift (SRA/SRAI).
  - MISC-MEM, SYSTEM, unknown: NOP (reg_write=0, branch_cond=NONE, ls_enable=0).
- rd=x0 forces reg_write_o=0.
- Immediates sign-extended to 32 bits.

## Timing
- Latency: 1 cycle, accept edge to output_valid_o.
- Reset: output_valid_o=0, all bundle outputs 0, branch_cond_o=NONE; input_ready_o=1 combinationally.
- Reset mid-operation discards the held bundle.
- Simultaneous output handshake and accept: new bundle replaces old, output_valid_o stays 1.
- output_ready_i=0 with valid held: input_ready_o=0; ifm stalls.

## Configuration
- DM_ILLEGAL_EN defined: unknown opcode, undefined funct3/funct7 for OP/OP-IMM/LOAD/STORE/BRANCH sets illegal_o=1 registered with the bundle, and the bundle is a NOP. SYSTEM and MISC-MEM are legal.
- DM_ILLEGAL_EN undefined: illegal_o tied 0; such instructions decode as NOP.

## Structure
- Shared package (ecap5_dproc_pkg): opcode constants, ALU funct3 constants, branch_cond enum NONE=0, BEQ, BNE, BLT, BGE, BLTU, BGEU, UNCOND=7.
- The same package also holds the store-select constants.
- Sub-module dm_imm: combinational I/S/B/U/J immediate extraction.

## Test plan
- 0x00500093 (ADDI x1,x0,5), rdt_data1_i=0 -> next cycle: op1=0, op2=5, alu_op=000, reg_write=1, reg_addr=1.
- 0x402081B3 (SUB x3,x1,x2), data 10/3 -> op1=10, op2=3, alu_sub=1, reg_addr=3.
- 0x00208463 (BEQ x1,x2,+8) at pc 0x100 -> branch_cond=BEQ, offset=4, reg_write=0, alu_sub=1.
- 0x010000EF (JAL x1,+16) at pc 0x200 -> op1=0x200, op2=4, UNCOND, offset=8, reg_addr=1.
- Stall: hold output_ready_i=0 for 3 cycles with input_valid_i=1 -> input_ready_o=0 and outputs stable. Release -> back-to-back accept, no bubble.
- Reset asserted with valid bundle -> output_valid_o=0 immediately. Opcode 0x7F with DM_ILLEGAL_EN -> illegal_o=1, reg_write=0.
